// File: rtl/clk_rst_gen.sv
// clk_rst_gen: per-channel clock dividers plus a staggered reset sequencer.
// Optional single-step clocking is built when CLK_RST_GEN_STEP_EN is defined.
module clk_rst_gen #(
    parameter int N_CH          = 2,
    parameter int CNT_W         = 16,
    parameter int DIV_DEFAULT   = 5000,
    parameter int RST_HOLD_LOG2 = 15,
    parameter int SEQ_GAP       = 16
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic [N_CH*CNT_W-1:0] div_value,
    input  logic [N_CH-1:0]       div_load,
    input  logic                  step_mode,
    input  logic                  step,
    output logic [N_CH-1:0]       clk_dut,
    output logic [N_CH-1:0]       rst_dut,
    output logic [N_CH-1:0]       step_busy,
    output logic                  locked
);

    localparam int HOLD_W = RST_HOLD_LOG2 + 1;
    localparam int GAP_W  = (SEQ_GAP > 1) ? $clog2(SEQ_GAP) : 1;

    typedef enum logic [1:0] {
        S_HOLD,
        S_SEQ,
        S_RUN
    } seq_state_t;

    seq_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [N_CH-1:0]   rdut_q, rdut_d;
    logic [N_CH-1:0]   rdut_nx;
    logic              lock_q, lock_d;

    // Releasing the lowest still-asserted reset is a left shift of the mask.
    assign rdut_nx = rdut_q << 1;

    // Sequencer state register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_HOLD;
            hold_q  <= '0;
            gap_q   <= '0;
            rdut_q  <= '1;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            rdut_q  <= rdut_d;
            lock_q  <= lock_d;
        end
    end

    // Sequencer next state: stretch, then drop channel resets one by one.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        rdut_d  = rdut_q;
        lock_d  = lock_q;
        unique case (state_q)
            S_HOLD: begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_q[RST_HOLD_LOG2]) begin
                    rdut_d = rdut_nx;
                    gap_d  = '0;
                    if (rdut_nx == '0) begin
                        state_d = S_RUN;
                        lock_d  = 1'b1;
                    end else begin
                        state_d = S_SEQ;
                    end
                end
            end
            S_SEQ: begin
                if (gap_q == GAP_W'(SEQ_GAP - 1)) begin
                    gap_d  = '0;
                    rdut_d = rdut_nx;
                    if (rdut_nx == '0) begin
                        state_d = S_RUN;
                        lock_d  = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    assign rst_dut = rdut_q;
    assign locked  = lock_q;

`ifdef CLK_RST_GEN_STEP_EN
    logic step_q;
    logic step_edge;

    // Previous step level for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_edge = step & ~step_q;
`else
    logic unused_step;
    assign unused_step = step_mode ^ step;
`endif

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] div_q;
        logic [CNT_W-1:0] shadow_q;
        logic             clk_q;
        logic             wrap;

        assign wrap       = (cnt_q == div_q);
        assign clk_dut[g] = clk_q;

`ifdef CLK_RST_GEN_STEP_EN
        logic busy_q;
        logic parked_q;

        assign step_busy[g] = busy_q;

        // Divider; a period ends at the low-half wrap, where parking happens.
        always_ff @(posedge CLK) begin
            if (rst) begin
                cnt_q    <= '0;
                div_q    <= CNT_W'(DIV_DEFAULT);
                shadow_q <= CNT_W'(DIV_DEFAULT);
                clk_q    <= 1'b0;
                busy_q   <= 1'b0;
                parked_q <= 1'b0;
            end else begin
                if (div_load[g]) begin
                    shadow_q <= div_value[g*CNT_W +: CNT_W];
                end
                if (parked_q) begin
                    if (!step_mode) begin
                        parked_q <= 1'b0;
                        clk_q    <= 1'b1;
                        cnt_q    <= '0;
                    end else if (step_edge) begin
                        parked_q <= 1'b0;
                        busy_q   <= 1'b1;
                        clk_q    <= 1'b1;
                        cnt_q    <= '0;
                    end
                end else if (wrap) begin
                    cnt_q <= '0;
                    if (clk_q) begin
                        clk_q <= 1'b0;
                        div_q <= shadow_q;
                    end else begin
                        busy_q <= 1'b0;
                        if (step_mode) begin
                            parked_q <= 1'b1;
                        end else begin
                            clk_q <= 1'b1;
                        end
                    end
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
`else
        assign step_busy[g] = 1'b0;

        // Free-running divider; new ratio takes effect on the falling wrap.
        always_ff @(posedge CLK) begin
            if (rst) begin
                cnt_q    <= '0;
                div_q    <= CNT_W'(DIV_DEFAULT);
                shadow_q <= CNT_W'(DIV_DEFAULT);
                clk_q    <= 1'b0;
            end else begin
                if (div_load[g]) begin
                    shadow_q <= div_value[g*CNT_W +: CNT_W];
                end
                if (wrap) begin
                    cnt_q <= '0;
                    clk_q <= ~clk_q;
                    if (clk_q) begin
                        div_q <= shadow_q;
                    end
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
`endif
    end

endmodule

// File: tb/tb_clk_rst_gen.sv
// tb_clk_rst_gen: self-checking bench for clk_rst_gen.
// Covers bring-up timing, ratio loads, reset abort and step mode.
module tb_clk_rst_gen;

    localparam int N_CH          = 2;
    localparam int CNT_W         = 8;
    localparam int DIV_DEFAULT   = 2;
    localparam int RST_HOLD_LOG2 = 4;
    localparam int SEQ_GAP       = 3;

    localparam logic [6:0] M_ALL = 7'h7F;
    localparam logic [6:0] M_CLK = 7'h60;
    localparam logic [6:0] M_CB  = 7'h66;

    logic                  CLK = 1'b0;
    logic                  rst;
    logic [N_CH*CNT_W-1:0] div_value;
    logic [N_CH-1:0]       div_load;
    logic                  step_mode;
    logic                  step;
    logic [N_CH-1:0]       clk_dut;
    logic [N_CH-1:0]       rst_dut;
    logic [N_CH-1:0]       step_busy;
    logic                  locked;

    clk_rst_gen #(
        .N_CH          (N_CH),
        .CNT_W         (CNT_W),
        .DIV_DEFAULT   (DIV_DEFAULT),
        .RST_HOLD_LOG2 (RST_HOLD_LOG2),
        .SEQ_GAP       (SEQ_GAP)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .div_value (div_value),
        .div_load  (div_load),
        .step_mode (step_mode),
        .step      (step),
        .clk_dut   (clk_dut),
        .rst_dut   (rst_dut),
        .step_busy (step_busy),
        .locked    (locked)
    );

    always #5 CLK = ~CLK;

    // Output vector layout: {clk_dut[1:0], rst_dut[1:0], step_busy[1:0], locked}
    typedef struct {
        string      name;
        logic [6:0] mask;
        logic [6:0] val;
    } exp_t;

    typedef struct {
        int         at_edge;
        logic [6:0] val;
    } vec_t;

    exp_t sb[$];
    vec_t tab[12];
    logic [1:0] ratio_exp[7];
    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
        edge_n++;
    endtask

    task automatic check_out();
        exp_t e;
        logic [6:0] act;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty edge=%0d", edge_n);
            return;
        end
        e   = sb.pop_front();
        act = {clk_dut, rst_dut, step_busy, locked};
        if ((act & e.mask) !== (e.val & e.mask)) begin
            errors++;
            $display("FAIL %s edge=%0d got=%b want=%b mask=%b",
                     e.name, edge_n, act, e.val, e.mask);
        end
    endtask

    task automatic cyc(input string name, input logic [6:0] mask,
                       input logic [6:0] val);
        exp_t e;
        e.name = name;
        e.mask = mask;
        e.val  = val;
        sb.push_back(e);
        tick();
        check_out();
    endtask

    task automatic cyc_clk(input string name, input logic [1:0] c);
        cyc(name, M_CLK, {c, 5'b00000});
    endtask

    task automatic cyc_cb(input string name, input logic [1:0] c,
                          input logic [1:0] b);
        cyc(name, M_CB, {c, 2'b00, b, 1'b0});
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        div_value = '0;
        div_load  = '0;
        step_mode = 1'b0;
        step      = 1'b0;
        repeat (2) tick();
        cyc("reset_state", M_ALL, 7'b0011000);
        rst    = 1'b0;
        edge_n = 0;
    endtask

    task automatic run_bringup();
        for (int i = 0; i < 12; i++) begin
            while (edge_n < tab[i].at_edge - 1) tick();
            cyc("bringup", M_ALL, tab[i].val);
        end
    endtask

    initial begin
        tab[0]  = '{1,  7'b0011000};
        tab[1]  = '{2,  7'b0011000};
        tab[2]  = '{3,  7'b1111000};
        tab[3]  = '{5,  7'b1111000};
        tab[4]  = '{6,  7'b0011000};
        tab[5]  = '{9,  7'b1111000};
        tab[6]  = '{16, 7'b1111000};
        tab[7]  = '{17, 7'b1110000};
        tab[8]  = '{18, 7'b0010000};
        tab[9]  = '{19, 7'b0010000};
        tab[10] = '{20, 7'b0000001};
        tab[11] = '{21, 7'b1100001};

        ratio_exp[0] = 2'b00;
        ratio_exp[1] = 2'b10;
        ratio_exp[2] = 2'b01;
        ratio_exp[3] = 2'b11;
        ratio_exp[4] = 2'b00;
        ratio_exp[5] = 2'b10;
        ratio_exp[6] = 2'b01;

        do_reset();
        run_bringup();

        // Ratio 0 on channel 1, loaded mid high-half.
        cyc_clk("ratio_pre", 2'b11);
        div_value = '0;
        div_load  = 2'b10;
        cyc_clk("load1_hold", 2'b11);
        div_load = 2'b00;
        cyc_clk("load1_wrap", 2'b00);
        cyc_clk("load1_fast", 2'b10);
        cyc_clk("load1_fast", 2'b00);
        cyc_clk("load1_fast", 2'b11);

        // Two loads on channel 0 before its wrap; the last one wins.
        div_value = {8'd0, 8'd5};
        div_load  = 2'b01;
        cyc_clk("load0_first", 2'b01);
        div_value = {8'd0, 8'd1};
        cyc_clk("load0_second", 2'b11);
        div_load = 2'b00;
        for (int k = 0; k < 7; k++) begin
            cyc_clk("load0_ratio1", ratio_exp[k]);
        end

        // Reset while locked and clk_dut[0] high aborts everything.
        rst = 1'b1;
        cyc("abort", M_ALL, 7'b0011000);
        rst    = 1'b0;
        edge_n = 0;
        run_bringup();

`ifdef CLK_RST_GEN_STEP_EN
        step_mode = 1'b1;
        cyc_cb("park_hi", 2'b11, 2'b00);
        cyc_cb("park_hi", 2'b11, 2'b00);
        cyc_cb("park_fall", 2'b00, 2'b00);
        for (int k = 25; k <= 30; k++) begin
            cyc_cb("parked", 2'b00, 2'b00);
        end
        step = 1'b1;
        cyc_cb("step_start", 2'b11, 2'b11);
        step = 1'b0;
        cyc_cb("step_hi", 2'b11, 2'b11);
        step = 1'b1;
        cyc_cb("step_ignored", 2'b11, 2'b11);
        step = 1'b0;
        for (int k = 34; k <= 36; k++) begin
            cyc_cb("step_lo", 2'b00, 2'b11);
        end
        for (int k = 37; k <= 40; k++) begin
            cyc_cb("step_done", 2'b00, 2'b00);
        end
        step_mode = 1'b0;
        for (int k = 41; k <= 43; k++) begin
            cyc_cb("resume", 2'b11, 2'b00);
        end
        cyc_cb("resume_fall", 2'b00, 2'b00);
`else
        step_mode = 1'b1;
        for (int k = 22; k <= 33; k++) begin
            step = (k % 2 == 0);
            cyc_cb("nostep_free", ((k / 3) % 2 == 1) ? 2'b11 : 2'b00, 2'b00);
        end
        step      = 1'b0;
        step_mode = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
